odd_count_checker: RTL and testbench
====================================

Name: odd_count_checker

Overview:
- Receive-side monitor for the odd up/down 4-bit counter.
- Samples the counter's Q output and its direction input Y every enabled clock.
- Locks onto the odd sequence 1,3,...,15 and predicts the next value.
- Flags any deviation, counts errors with saturation, and reports direction changes; sits beside the counter in the counter bench and system.

Parameters:
- WIDTH, 4: width of the sampled count.
- ERR_W, 8: width of the saturating error counter.
- LOCK_N, 2: consecutive matching samples (including the seed) required to assert locked.

Ports:
- clk  in  1  rising-edge clock, shared with the counter.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  sample-valid; when low, all state holds.
- Q  in  WIDTH  counter output being checked.
- Y  in  1  counter direction (0 = up, 1 = down), sampled with Q.
- locked  out  1  sequence tracked; high in LOCKED.
- err  out  1  one-cycle pulse on a mismatch while LOCKED.
- err_cnt  out  ERR_W  saturating count of err pulses.
- expected  out  WIDTH  predicted next Q.
- dir_chg  out  1  one-cycle pulse when sampled Y differs from the previous sampled Y.

Behaviour:
- Reset (rst=0, async): state=HUNT, locked=0, err=0, err_cnt=0, expected=0, dir_chg=0, prev_y=0, good_cnt=0.
- All outputs are registered; a sample taken at edge n is reflected after edge n.
- next(q,y):
  - up: q+2, with 15 wrapping to 1.
  - down: q-2, with 1 wrapping to 15.
  - Arithmetic is mod 2^WIDTH on odd values only.
- Sample: on each edge with en=1, capture Q, Y. On each edge with en=0, hold everything; err and dir_chg are 0.
- FSM:
  - HUNT:
    - Q odd: expected=next(Q,Y), good_cnt=1, go to SYNC. If LOCK_N=1, go straight to LOCKED.
    - Q even: stay; no err.
  - SYNC:
    - Q==expected: good_cnt+1, expected=next(Q,Y); at good_cnt==LOCK_N go to LOCKED.
    - Q odd and mismatched: reseed (expected=next(Q,Y), good_cnt=1), stay in SYNC.
    - Q even: go to HUNT.
    - No err in SYNC.
  - LOCKED:
    - Q==expected: expected=next(Q,Y), stay.
    - Mismatch: err=1 for one cycle, err_cnt+1 saturating at 2^ERR_W-1, locked=0.
    - After a mismatch, reseed to SYNC if Q is odd, else go to HUNT.
- locked = (state==LOCKED), registered.
- dir_chg=1 for one cycle when en=1 and Y!=prev_y; prev_y updates on every enabled sample. The first sample after reset compares against prev_y=0.
- A direction change is never an error; the prediction always uses the Y sampled with the same Q.
- Async reset mid-lock: all outputs clear immediately, independent of clk.

Decomposition:
- Package odd_count_pkg:
  - state enum HUNT/SYNC/LOCKED (2-bit).
  - constants ODD_MIN=1, ODD_MAX=2^WIDTH-1.
- Sub-module odd_step: combinational next(q,y) with wrap handling, reusable by the counter's own model.

Test Plan:
1. rst=0 for 10 ns, then 1; en=1; Q=0.
   - During reset: locked=0, err=0, err_cnt=0, expected=0.
   - After release: no err while Q stays even.
2. Up sequence, Y=0, Q=1,3,5.
   - After 1: SYNC, expected=3.
   - After 3: locked=1, expected=5.
   - After 5: expected=7, err=0.
3. Wrap.
   - Locked at Q=15, Y=0: expected=1.
   - Then Q=1, Y=1: dir_chg=1 for one cycle, expected=15, no err.
4. Mid-run direction change.
   - Locked, Q=7 with Y=0: expected=9.
   - Y goes 1 with Q=9: dir_chg pulse, expected=7.
   - Then Q=7, Y=1: expected=5, locked stays 1.
5. Injected fault.
   - Locked with expected=9; drive Q=10: err=1 for one cycle, err_cnt=1, locked=0, state HUNT.
   - Q=12: no err.
   - Q=1,3: relocked.
6. Saturation and reset.
   - With ERR_W=2, force 5 locked mismatches: err_cnt reaches 3 and stays 3.
   - Assert rst=0 between clock edges: err_cnt=0 and locked=0 immediately.
   - en=0 for 3 cycles: expected unchanged.

Source files
------------

// File: rtl/odd_count_pkg.sv
// ============================================================================
// Module      : odd_count_pkg
// Description : Shared types and constants for the odd up/down counter
//               checker: FSM state encoding and odd-range limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package odd_count_pkg;

    // Tracking states of the checker
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Default sampled-count width of the odd counter
    localparam int ODD_W   = 4;

    // Smallest odd value in the sequence
    localparam int ODD_MIN = 1;

    // Largest odd value representable in w bits
    function automatic int odd_max(input int w);
        return (2 ** w) - 1;
    endfunction

    // Largest odd value for the default width
    localparam int ODD_MAX = odd_max(ODD_W);

endpackage : odd_count_pkg

`default_nettype wire

// File: rtl/odd_step.sv
// ============================================================================
// Module      : odd_step
// Description : Combinational successor of an odd count value. Steps by +2
//               (up) or -2 (down) with wrap MAX->MIN and MIN->MAX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module odd_step
    import odd_count_pkg::*;
#(
    parameter int WIDTH = ODD_W
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             y_i,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH-1:0] C_MIN  = WIDTH'(ODD_MIN);
    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(odd_max(WIDTH));
    localparam logic [WIDTH-1:0] C_STEP = WIDTH'(2);

    // Wrap is spelled out so the intent survives a reader who forgets the
    // modulo arithmetic would produce the same result for odd inputs.
    always_comb begin
        next_o = q_i;
        if (!y_i) begin
            next_o = (q_i == C_MAX) ? C_MIN : (q_i + C_STEP);
        end else begin
            next_o = (q_i == C_MIN) ? C_MAX : (q_i - C_STEP);
        end
    end

endmodule : odd_step

`default_nettype wire

// File: rtl/odd_count_checker.sv
// ============================================================================
// Module      : odd_count_checker
// Description : Receive-side monitor for the odd up/down counter. Locks onto
//               the odd sequence, predicts the next value, flags and counts
//               (saturating) mismatches and reports direction changes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module odd_count_checker
    import odd_count_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int LOCK_N = 2
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active-low
    input  logic             en,
    input  logic [WIDTH-1:0] Q,
    input  logic             Y,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] expected,
    output logic             dir_chg
);

    // good_cnt never exceeds LOCK_N, one spare value keeps the increment safe
    localparam int               GOOD_W      = $clog2(LOCK_N + 2);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic             SEED_LOCKS  = (LOCK_N <= 1);

    state_e              state_q,    state_d;
    logic [WIDTH-1:0]    exp_q,      exp_d;
    logic [GOOD_W-1:0]   good_q,     good_d;
    logic [ERR_W-1:0]    err_cnt_q,  err_cnt_d;
    logic                err_q,      err_d;
    logic                locked_q,   locked_d;
    logic                prev_y_q,   prev_y_d;
    logic                dir_chg_q,  dir_chg_d;

    logic [WIDTH-1:0]    next_w;
    logic [GOOD_W-1:0]   good_inc_w;

    // Every prediction is formed from the Q/Y pair sampled together
    odd_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i    (Q),
        .y_i    (Y),
        .next_o (next_w)
    );

    assign good_inc_w = good_q + GOOD_W'(1);

    // Tracking FSM, prediction and error accounting for one enabled sample
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        good_d    = good_q;
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
        if (en) begin
            unique case (state_q)
                HUNT: begin
                    // An odd value seeds the prediction; even values are noise
                    if (Q[0]) begin
                        exp_d   = next_w;
                        good_d  = GOOD_W'(1);
                        state_d = SEED_LOCKS ? LOCKED : SYNC;
                    end
                end
                SYNC: begin
                    if (Q == exp_q) begin
                        exp_d  = next_w;
                        good_d = good_inc_w;
                        if (int'(good_inc_w) >= LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end else if (Q[0]) begin
                        // Reseed from the new odd value, no error while syncing
                        exp_d   = next_w;
                        good_d  = GOOD_W'(1);
                        state_d = SEED_LOCKS ? LOCKED : SYNC;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (Q == exp_q) begin
                        exp_d = next_w;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (Q[0]) begin
                            exp_d   = next_w;
                            good_d  = GOOD_W'(1);
                            state_d = SEED_LOCKS ? LOCKED : SYNC;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // Direction-change detect against the previously sampled Y
    always_comb begin
        dir_chg_d = en & (Y != prev_y_q);
        prev_y_d  = en ? Y : prev_y_q;
        locked_d  = (state_d == LOCKED);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HUNT;
            exp_q     <= '0;
            good_q    <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            prev_y_q  <= 1'b0;
            dir_chg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            good_q    <= good_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            prev_y_q  <= prev_y_d;
            dir_chg_q <= dir_chg_d;
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign expected = exp_q;
    assign dir_chg  = dir_chg_q;

endmodule : odd_count_checker

`default_nettype wire

// File: tb/tb_odd_count_checker.sv
// ============================================================================
// Module      : tb_odd_count_checker
// Description : Self-checking bench for odd_count_checker. Directed scenarios
//               plus randomized traffic against a behavioural model; a second
//               instance with a 2-bit error counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_odd_count_checker;

    localparam int LOCK_N = 2;
    localparam int M_HUNT = 0;
    localparam int M_SYNC = 1;
    localparam int M_LOCK = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [3:0] Q   = 4'd0;
    logic       Y   = 1'b0;

    logic       locked, err, dir_chg;
    logic [7:0] err_cnt;
    logic [3:0] expected;
    logic       s_locked, s_err, s_dir_chg;
    logic [1:0] s_err_cnt;
    logic [3:0] s_expected;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_state, m_exp, m_good, m_prev, m_errs, m_err, m_dir;

    odd_count_checker #(.WIDTH(4), .ERR_W(8), .LOCK_N(LOCK_N)) dut (
        .clk(clk), .rst(rst), .en(en), .Q(Q), .Y(Y),
        .locked(locked), .err(err), .err_cnt(err_cnt),
        .expected(expected), .dir_chg(dir_chg)
    );

    odd_count_checker #(.WIDTH(4), .ERR_W(2), .LOCK_N(LOCK_N)) dut_s (
        .clk(clk), .rst(rst), .en(en), .Q(Q), .Y(Y),
        .locked(s_locked), .err(s_err), .err_cnt(s_err_cnt),
        .expected(s_expected), .dir_chg(s_dir_chg)
    );

    always #5 clk = ~clk;

    function automatic int nxt(input int q, input int y);
        if (y == 0) return (q == 15) ? 1 : q + 2;
        else        return (q == 1) ? 15 : q - 2;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_state = M_HUNT; m_exp = 0; m_good = 0; m_prev = 0;
        m_errs = 0; m_err = 0; m_dir = 0;
    endtask

    task automatic model_seed(input int q, input int y);
        m_exp   = nxt(q, y);
        m_good  = 1;
        m_state = (LOCK_N <= 1) ? M_LOCK : M_SYNC;
    endtask

    task automatic model_sample(input int e, input int q, input int y);
        m_err = 0;
        m_dir = 0;
        if (e != 0) begin
            m_dir  = (y != m_prev) ? 1 : 0;
            m_prev = y;
            if (m_state == M_HUNT) begin
                if (q % 2 == 1) model_seed(q, y);
            end else if (m_state == M_SYNC) begin
                if (q == m_exp) begin
                    m_good = m_good + 1;
                    m_exp  = nxt(q, y);
                    if (m_good >= LOCK_N) m_state = M_LOCK;
                end else if (q % 2 == 1) model_seed(q, y);
                else m_state = M_HUNT;
            end else begin
                if (q == m_exp) m_exp = nxt(q, y);
                else begin
                    m_err  = 1;
                    m_errs = m_errs + 1;
                    if (q % 2 == 1) model_seed(q, y);
                    else m_state = M_HUNT;
                end
            end
        end
    endtask

    // one sample: apply inputs, clock, advance model, settle
    task automatic drive(input logic e, input logic [3:0] q, input logic y);
        en = e; Q = q; Y = y;
        @(posedge clk);
        model_sample(int'(e), int'(q), int'(y));
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; Q = 4'd0; Y = 1'b0;
        model_reset();
        #2;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        checks++; if (expected !== 4'd0) begin errors++; $display("FAIL reset_expected got %0d want 0", expected); end
        checks++; if (dir_chg !== 1'b0) begin errors++; $display("FAIL reset_dir_chg got %0b want 0", dir_chg); end
        #8 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 1'b0);
            checks++; if (err !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL even_hunt err=%0b locked=%0b want 0 0", err, locked); end
        end
    endtask

    task automatic test_up_sequence();
        drive(1'b1, 4'd1, 1'b0);
        checks++; if (locked !== 1'b0 || expected !== 4'd3) begin errors++; $display("FAIL up_after1 locked=%0b exp=%0d want 0 3", locked, expected); end
        drive(1'b1, 4'd3, 1'b0);
        checks++; if (locked !== 1'b1 || expected !== 4'd5) begin errors++; $display("FAIL up_after3 locked=%0b exp=%0d want 1 5", locked, expected); end
        drive(1'b1, 4'd5, 1'b0);
        checks++; if (expected !== 4'd7 || err !== 1'b0) begin errors++; $display("FAIL up_after5 exp=%0d err=%0b want 7 0", expected, err); end
    endtask

    task automatic test_wrap();
        for (int v = 7; v <= 15; v += 2) drive(1'b1, 4'(v), 1'b0);
        checks++; if (locked !== 1'b1 || expected !== 4'd1) begin errors++; $display("FAIL wrap_up locked=%0b exp=%0d want 1 1", locked, expected); end
        drive(1'b1, 4'd1, 1'b1);
        checks++; if (dir_chg !== 1'b1 || expected !== 4'd15 || err !== 1'b0) begin errors++; $display("FAIL wrap_down dir=%0b exp=%0d err=%0b want 1 15 0", dir_chg, expected, err); end
        drive(1'b1, 4'd15, 1'b1);
        checks++; if (dir_chg !== 1'b0 || expected !== 4'd13) begin errors++; $display("FAIL wrap_pulse dir=%0b exp=%0d want 0 13", dir_chg, expected); end
    endtask

    task automatic test_dir_change();
        drive(1'b1, 4'd13, 1'b1);
        drive(1'b1, 4'd11, 1'b1);
        drive(1'b1, 4'd9, 1'b1);
        drive(1'b1, 4'd7, 1'b0);
        checks++; if (expected !== 4'd9 || dir_chg !== 1'b1) begin errors++; $display("FAIL dir_q7 exp=%0d dir=%0b want 9 1", expected, dir_chg); end
        drive(1'b1, 4'd9, 1'b1);
        checks++; if (expected !== 4'd7 || dir_chg !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL dir_q9 exp=%0d dir=%0b err=%0b want 7 1 0", expected, dir_chg, err); end
        drive(1'b1, 4'd7, 1'b1);
        checks++; if (expected !== 4'd5 || locked !== 1'b1 || dir_chg !== 1'b0) begin errors++; $display("FAIL dir_q7b exp=%0d locked=%0b dir=%0b want 5 1 0", expected, locked, dir_chg); end
    endtask

    task automatic test_fault();
        drive(1'b1, 4'd5, 1'b0);
        drive(1'b1, 4'd7, 1'b0);
        checks++; if (expected !== 4'd9 || locked !== 1'b1) begin errors++; $display("FAIL fault_pre exp=%0d locked=%0b want 9 1", expected, locked); end
        drive(1'b1, 4'd10, 1'b0);
        checks++; if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin errors++; $display("FAIL fault_hit err=%0b cnt=%0d locked=%0b want 1 1 0", err, err_cnt, locked); end
        drive(1'b1, 4'd12, 1'b0);
        checks++; if (err !== 1'b0 || err_cnt !== 8'd1 || locked !== 1'b0) begin errors++; $display("FAIL fault_hunt err=%0b cnt=%0d locked=%0b want 0 1 0", err, err_cnt, locked); end
        drive(1'b1, 4'd1, 1'b0);
        drive(1'b1, 4'd3, 1'b0);
        checks++; if (locked !== 1'b1 || expected !== 4'd5) begin errors++; $display("FAIL fault_relock locked=%0b exp=%0d want 1 5", locked, expected); end
    endtask

    task automatic test_saturation_reset();
        // fresh start so both counters begin at zero
        #3 rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 4'd1, 1'b0);
            drive(1'b1, 4'd3, 1'b0);
            drive(1'b1, 4'd4, 1'b0);
            checks++; if (s_err !== 1'b1 || s_err_cnt !== 2'(sat(i, 3))) begin errors++; $display("FAIL sat_small i=%0d err=%0b cnt=%0d want 1 %0d", i, s_err, s_err_cnt, sat(i, 3)); end
            checks++; if (err_cnt !== 8'(i)) begin errors++; $display("FAIL sat_wide i=%0d cnt=%0d want %0d", i, err_cnt, i); end
        end
        drive(1'b1, 4'd1, 1'b0);
        drive(1'b1, 4'd3, 1'b0);
        checks++; if (s_err_cnt !== 2'd3 || locked !== 1'b1) begin errors++; $display("FAIL sat_hold cnt=%0d locked=%0b want 3 1", s_err_cnt, locked); end
        // reset asserted between clock edges must clear at once
        #3 rst = 1'b0;
        #1;
        checks++; if (err_cnt !== 8'd0 || s_err_cnt !== 2'd0 || locked !== 1'b0 || expected !== 4'd0) begin errors++; $display("FAIL async_rst cnt=%0d scnt=%0d locked=%0b exp=%0d want 0 0 0 0", err_cnt, s_err_cnt, locked, expected); end
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_enable_hold();
        drive(1'b1, 4'd1, 1'b0);
        drive(1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            checks++; if (expected !== 4'd5 || err !== 1'b0 || dir_chg !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL en_hold exp=%0d err=%0b dir=%0b locked=%0b want 5 0 0 1", expected, err, dir_chg, locked); end
        end
        drive(1'b1, 4'd5, 1'b0);
        checks++; if (expected !== 4'd7) begin errors++; $display("FAIL en_resume exp=%0d want 7", expected); end
    endtask

    task automatic test_random();
        logic [3:0] q;
        logic       y, e;
        y = Y;
        for (int c = 0; c < 400; c++) begin
            if (m_exp % 2 == 1 && $urandom_range(0, 9) < 7) q = 4'(m_exp);
            else q = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) y = ~y;
            e = ($urandom_range(0, 9) != 0);
            drive(e, q, y);
            checks++; if (expected !== 4'(m_exp) || s_expected !== 4'(m_exp)) begin errors++; $display("FAIL rnd_expected c=%0d got %0d/%0d want %0d", c, expected, s_expected, m_exp); end
            checks++; if (locked !== (m_state == M_LOCK) || s_locked !== (m_state == M_LOCK)) begin errors++; $display("FAIL rnd_locked c=%0d got %0b/%0b want %0b", c, locked, s_locked, m_state == M_LOCK); end
            checks++; if (err !== 1'(m_err) || s_err !== 1'(m_err)) begin errors++; $display("FAIL rnd_err c=%0d got %0b/%0b want %0d", c, err, s_err, m_err); end
            checks++; if (dir_chg !== 1'(m_dir) || s_dir_chg !== 1'(m_dir)) begin errors++; $display("FAIL rnd_dir c=%0d got %0b/%0b want %0d", c, dir_chg, s_dir_chg, m_dir); end
            checks++; if (err_cnt !== 8'(sat(m_errs, 255)) || s_err_cnt !== 2'(sat(m_errs, 3))) begin errors++; $display("FAIL rnd_err_cnt c=%0d got %0d/%0d want %0d/%0d", c, err_cnt, s_err_cnt, sat(m_errs, 255), sat(m_errs, 3)); end
        end
    endtask

    initial begin
        test_reset();
        test_up_sequence();
        test_wrap();
        test_dir_change();
        test_fault();
        test_saturation_reset();
        test_enable_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_odd_count_checker

`default_nettype wire
